seg7_mux_driver: RTL and testbench
==================================

// Module: seg7_mux_driver
// PURPOSE
//  Time-multiplexed driver for a common-anode, N-digit hex 7-segment display.
//  Each digit is a 4-bit nibble. The block latches a display word and scans one digit at a time.
//  Each digit slot starts with a ghost-blanking gap.
//  Supports per-digit decimal points, per-digit enables and optional leading-zero suppression.
//  Sits between datapath result registers and the board pins an/seg/dp.
//  Generalises the single-digit, anode-fixed hex decoder to N scanned digits.
// PARAMETERS
//  DIGITS       4      number of digits/anodes; >=1
//  REFRESH_DIV  100000 clk cycles per digit slot; >=2; slot cycle 0 is the blank gap
//  LZ_SUPPRESS  0      1 = blank leading zero digits (digit 0 always shown)
// PORTS
//  clk       in   1          system clock, all state on rising edge
//  rst_n     in   1          asynchronous, active-low reset
//  value     in   4*DIGITS   hex nibbles; nibble i = value[4i+3:4i] drives anode i
//  dp_in     in   DIGITS     decimal point request per digit, 1 = lit
//  digit_en  in   DIGITS     per-digit enable, 0 = digit dark
//  load      in   1          1-cycle strobe: capture value/dp_in/digit_en into shadow regs
//  an        out  DIGITS     anodes, active-low, registered
//  seg       out  7          segments, active-low, registered; seg[6]=a ... seg[0]=g
//  dp        out  1          decimal point, active-low, registered
// BEHAVIOUR
//  - Reset (async, rst_n=0): an='1, seg=7'b1111111, dp=1. slot_cnt=0, idx=0, shadows=0.
//    Deassertion is synchronous to clk through the standard reset synchroniser upstream.
//  - Shadow load: when load=1 at edge n, the shadows take the inputs at edge n.
//    The new data reaches the pins at the next non-gap cycle of each digit's slot.
//    Between loads the inputs are ignored, so the display never tears mid-scan.
//  - slot_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
//    On wrap, idx <= (idx==DIGITS-1) ? 0 : idx+1.
//  - Registered outputs, computed from the current slot_cnt/idx:
//      gap   = (slot_cnt==0)
//      dark  = gap | ~en_sh[idx] | lz_blank(idx)
//      an   <= dark ? '1 : ~(1<<idx)
//      seg  <= dark ? SEG_BLANK : hex_to_seg7(nib_sh[idx])
//      dp   <= dark ? 1 : ~dp_sh[idx]
//    Output latency is 1 cycle from the counter state.
//    An anode is low for REFRESH_DIV-1 consecutive cycles per slot.
//    At most one anode is low at any time.
//  - lz_blank(i): LZ_SUPPRESS=1 and i!=0 and nibbles DIGITS-1..i are all 0. Otherwise 0.
//    dp_sh[i]=1 cancels suppression for digit i and all digits below it.
//  - Hex font, active-low {a..g}:
//      0=0000001  1=1001111  2=0010010  3=0000110
//      4=1001100  5=0100100  6=0100000  7=0001111
//      8=0000000  9=0000100  A=0001000  b=1100000
//      C=0110001  d=1000010  E=0110000  F=0111000
//  - load coinciding with a slot wrap: the shadows update and idx advances in the same edge.
//    The new digit shows the new data after its gap cycle.
//  - Reset mid-scan: outputs go dark immediately. The scan restarts at idx=0 with a gap cycle.
//  - DIGITS=1: idx is constant 0. A gap cycle still occurs every REFRESH_DIV cycles.
// STRUCTURE
//  - Package seg7_pkg:
//      SEG_BLANK = 7'b1111111
//      typedef logic [6:0] seg7_t
//      function hex_to_seg7(input [3:0]) returning seg7_t, holding the font table above
//  - Sub-module seg7_hex_decode: purely combinational nibble -> seg7_t wrapper of the package function.
//    One instance is fed by the muxed nibble.
//  - Top level: shadow regs, slot counter, digit index, LZ scan (combinational OR chain), output regs.
// TESTING
//  Bench params: DIGITS=4, REFRESH_DIV=4 (scan period 16 clk).
//  - Reset: hold rst_n=0 three cycles, mid-clock deassert -> an=1111, seg=1111111, dp=1 throughout.
//    First anode (an=1110) goes low at cycle 2 after release.
//  - Scan: load value=16'h12AF, digit_en=1111, dp_in=0000.
//    -> digits 0..3 show F(0111000), A(0001000), 2(0010010), 1(1001111).
//    Each digit is lit 3 cycles, then 1 all-dark cycle; an cycles 1110,1101,1011,0111.
//  - Tear-free: change value to 16'h0000 without load -> display unchanged for 64 cycles.
//    Pulse load -> all digits show 0000001 by the next full scan.
//  - LZ: LZ_SUPPRESS=1, load value=16'h0050 -> digits 3,2 dark (an bit stays 1); digit1=5, digit0=0.
//    Then dp_in=0100 -> digit2 shows 0 with dp=0.
//  - Enable/dp: digit_en=1010, dp_in=0010 -> anodes 0 and 2 never low. dp=0 only in digit 1's lit cycles.
//  - Reset mid-scan at idx=2, slot_cnt=2 -> outputs dark in the same cycle.
//    After release the scan resumes at an=1110.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and the hex font for the multiplexed 7-segment driver.
// Segment vectors are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'b1111111;

   function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
      seg7_t s;
      case (nib)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_mux_driver_hex_decode.sv
// Combinational nibble to active-low segment pattern.
// Thin wrapper so the font lives in exactly one place (the package).
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output seg7_t      seg
);

   assign seg = hex_to_seg7(nib);

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit hex 7-segment driver for a common-anode display.
// Data is captured into shadows on load; each digit slot opens with one blank gap cycle.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit LZ_SUPPRESS = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output seg7_t                 seg,
   output logic                  dp
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   logic [DIGITS-1:0][3:0] nib_sh;
   logic [DIGITS-1:0]      dp_sh;
   logic [DIGITS-1:0]      en_sh;
   logic [SW-1:0]          slot_cnt;
   logic [IW-1:0]          idx;

   logic [DIGITS:0]        zero_run;
   logic [DIGITS-1:0]      lz_blank;
   logic                   dark;
   logic [3:0]             nib_cur;
   seg7_t                  seg_cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_sh <= '0;
         dp_sh  <= '0;
         en_sh  <= '0;
      end else if (load) begin
         nib_sh <= value;
         dp_sh  <= dp_in;
         en_sh  <= digit_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else if (slot_cnt == SLOT_LAST) begin
         slot_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // zero_run[i]: every nibble from the top down to i is zero and no dp is requested there
   always_comb begin
      zero_run         = '0;
      lz_blank         = '0;
      zero_run[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run[i] = zero_run[i+1] & (nib_sh[i] == 4'h0) & ~dp_sh[i];
         lz_blank[i] = LZ_SUPPRESS && (i != 0) && zero_run[i];
      end
   end

   assign nib_cur = nib_sh[idx];
   assign dark    = (slot_cnt == '0) | ~en_sh[idx] | lz_blank[idx];

   seg7_hex_decode u_hex_decode (
      .nib (nib_cur),
      .seg (seg_cur)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if (dark) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(DIGITS'(1) << idx);
         seg <= seg_cur;
         dp  <= ~dp_sh[idx];
      end
   end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: 4 digits, 4-cycle slots (16-cycle scan).
// Instance u_dut0 has leading-zero suppression off, u_dut1 has it on; both share inputs.
module tb_seg7_mux_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        load;
   logic [3:0]  an0, an1;
   logic [6:0]  seg0, seg1;
   logic        dp0, dp1;

   int checks;
   int errors;
   int cyc;

   seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .LZ_SUPPRESS(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
      .load(load), .an(an0), .seg(seg0), .dp(dp0)
   );

   seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .LZ_SUPPRESS(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
      .load(load), .an(an1), .seg(seg1), .dp(dp1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // clock edges since reset release; after edge k the pins show counter state k-1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   localparam logic [6:0] F_0 = 7'b0000001;
   localparam logic [6:0] F_1 = 7'b1001111;
   localparam logic [6:0] F_2 = 7'b0010010;
   localparam logic [6:0] F_5 = 7'b0100100;
   localparam logic [6:0] F_A = 7'b0001000;
   localparam logic [6:0] F_F = 7'b0111000;
   localparam logic [6:0] BLK = 7'b1111111;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_pins(input int sel, input string tag,
                             input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
      logic [3:0] a;
      logic [6:0] s;
      logic       d;
      a = (sel == 0) ? an0  : an1;
      s = (sel == 0) ? seg0 : seg1;
      d = (sel == 0) ? dp0  : dp1;
      check({tag, ".an"},  32'(a), 32'(e_an));
      check({tag, ".seg"}, 32'(s), 32'(e_seg));
      check({tag, ".dp"},  32'(d), 32'(e_dp));
   endtask

   // es[d]: expected segments of digit d; lit[d]: digit visible; dpl[d]: dp expected lit
   task automatic check_scan(input int sel, input string tag, input logic [3:0][6:0] es,
                             input logic [3:0] lit, input logic [3:0] dpl);
      int n;
      n = 0;
      while (cyc % 16 != 0) begin
         @(negedge clk);
         n++;
         if (n > 40) begin
            check({tag, ".boundary_timeout"}, 32'(n), 32'(0));
            return;
         end
      end
      for (int j = 0; j < 16; j++) begin
         int t, slot, d;
         @(negedge clk);
         t    = cyc - 1;
         slot = t % 4;
         d    = (t / 4) % 4;
         if (slot == 0 || !lit[d])
            check_pins(sel, $sformatf("%s.c%0d", tag, j), 4'hF, BLK, 1'b1);
         else
            check_pins(sel, $sformatf("%s.c%0d", tag, j), ~(4'b0001 << d), es[d], ~dpl[d]);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
      @(negedge clk);
      value = v; digit_en = en; dp_in = dpv; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // release mid-clock with a load pending so the first edge captures display data
   task automatic release_with_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
      value = v; digit_en = en; dp_in = dpv; load = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      logic [3:0][6:0] s_12af, s_zero, s_0050, s_lz, s_lzdp;
      int n;
      checks = 0; errors = 0;
      rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
      s_12af = {F_1, F_2, F_A, F_F};
      s_zero = {F_0, F_0, F_0, F_0};
      s_0050 = {F_0, F_0, F_5, F_0};
      s_lz   = {BLK, BLK, F_5, F_0};
      s_lzdp = {BLK, F_0, F_5, F_0};

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_pins(0, "reset_hold", 4'hF, BLK, 1'b1);
      end
      release_with_load(16'h12AF, 4'hF, 4'h0);
      check_pins(0, "post_rel_c1", 4'hF, BLK, 1'b1);
      @(negedge clk);
      check_pins(0, "post_rel_c2", 4'b1110, F_F, 1'b1);

      check_scan(0, "scan_12af", s_12af, 4'hF, 4'h0);
      check_scan(1, "scan_12af_lz", s_12af, 4'hF, 4'h0);

      value = 16'h0000;
      for (int k = 0; k < 4; k++) check_scan(0, "tear_free", s_12af, 4'hF, 4'h0);
      do_load(16'h0000, 4'hF, 4'h0);
      check_scan(0, "all_zero", s_zero, 4'hF, 4'h0);
      check_scan(1, "all_zero_lz", s_zero, 4'b0001, 4'h0);

      do_load(16'h0050, 4'hF, 4'h0);
      check_scan(1, "lz_0050", s_lz, 4'b0011, 4'h0);
      check_scan(0, "nolz_0050", s_0050, 4'hF, 4'h0);
      do_load(16'h0050, 4'hF, 4'b0100);
      check_scan(1, "lz_dp2", s_lzdp, 4'b0111, 4'b0100);

      do_load(16'h12AF, 4'hF, 4'h0);
      check_scan(0, "reload_12af", s_12af, 4'hF, 4'h0);
      n = 0;
      while (cyc % 16 != 10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("midrst_align", 32'(cyc % 16), 32'(10));
      check_pins(0, "pre_midrst", 4'b1011, F_2, 1'b1);
      rst_n = 1'b0;
      #1;
      check_pins(0, "midrst_now", 4'hF, BLK, 1'b1);
      @(negedge clk);
      check_pins(0, "midrst_hold", 4'hF, BLK, 1'b1);
      release_with_load(16'h12AF, 4'hF, 4'h0);
      check_pins(0, "midrst_rel_c1", 4'hF, BLK, 1'b1);
      @(negedge clk);
      check_pins(0, "midrst_rel_c2", 4'b1110, F_F, 1'b1);
      check_scan(0, "after_midrst", s_12af, 4'hF, 4'h0);

      do_load(16'h12AF, 4'b1010, 4'b0010);
      check_scan(0, "en_dp", s_12af, 4'b1010, 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, cyc %0d", cyc);
      $fatal(1);
   end

endmodule
